// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Brief    : Two-port (CPU / debug) arbiter sharing one unified memory.
//            Accesses are serialised by an IDLE/ACCESS/RESP sequencer with a
//            req/ack handshake. CPU has fixed priority; the debug port is
//            guaranteed a grant after MAX_WAIT lost contested decisions.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int MAX_WAIT = 4,
    parameter int AW       = 32,
    parameter int DW       = 32
) (
    input  logic          clk,
    input  logic          reset,
    // CPU port
    input  logic          c_req,
    input  logic          c_we,
    input  logic [AW-1:0] c_addr,
    input  logic [DW-1:0] c_wdata,
    output logic [DW-1:0] c_rdata,
    output logic          c_ack,
    // debug port
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_ack,
    // memory side
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata,
    output logic [1:0]    owner
);

    // Wait counter is at least 3 bits and wide enough to hold MAX_WAIT.
    localparam int             WCW        = ($clog2(MAX_WAIT + 1) > 3) ? $clog2(MAX_WAIT + 1) : 3;
    localparam logic [WCW-1:0] C_MAX_WAIT = WCW'(MAX_WAIT);

    localparam logic [1:0] C_OWN_NONE = 2'b00;
    localparam logic [1:0] C_OWN_CPU  = 2'b01;
    localparam logic [1:0] C_OWN_DBG  = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic           w_grant_c;
    logic           w_grant_d;
    logic           w_contested;

    logic           r_we;
    logic [AW-1:0]  r_addr;
    logic [DW-1:0]  r_wdata;
    logic [1:0]     r_owner;
    logic [WCW-1:0] r_wait_cnt;
    logic [DW-1:0]  r_c_rdata;
    logic [DW-1:0]  r_d_rdata;

    // Sequencer state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and grant decision; grants are only ever issued in IDLE.
    always_comb begin
        w_state_nxt = r_state;
        w_grant_c   = 1'b0;
        w_grant_d   = 1'b0;
        w_contested = c_req & d_req;
        case (r_state)
            S_IDLE: begin
                if (w_contested) begin
                    // Debug port wins only once it has lost MAX_WAIT times in a row.
                    if ((MAX_WAIT != 0) && (r_wait_cnt == C_MAX_WAIT)) begin
                        w_grant_d = 1'b1;
                    end else begin
                        w_grant_c = 1'b1;
                    end
                end else begin
                    w_grant_c = c_req;
                    w_grant_d = d_req;
                end
                if (c_req || d_req) begin
                    w_state_nxt = S_ACCESS;
                end
            end
            S_ACCESS: w_state_nxt = S_RESP;
            S_RESP:   w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Latch the winner's request fields and ownership at the grant edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_owner <= C_OWN_NONE;
        end else if (w_grant_c) begin
            r_we    <= c_we;
            r_addr  <= c_addr;
            r_wdata <= c_wdata;
            r_owner <= C_OWN_CPU;
        end else if (w_grant_d) begin
            r_we    <= d_we;
            r_addr  <= d_addr;
            r_wdata <= d_wdata;
            r_owner <= C_OWN_DBG;
        end
    end

    // Starvation counter: counts contested losses of the debug port, saturating.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wait_cnt <= '0;
        end else if (w_grant_d) begin
            r_wait_cnt <= '0;
        end else if (w_contested && w_grant_c && (r_wait_cnt != C_MAX_WAIT)) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
        end
    end

    // Capture memory read data for the owning port at the end of ACCESS.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_c_rdata <= '0;
            r_d_rdata <= '0;
        end else if (r_state == S_ACCESS) begin
            if (r_owner == C_OWN_CPU) begin
                r_c_rdata <= m_rdata;
            end
            if (r_owner == C_OWN_DBG) begin
                r_d_rdata <= m_rdata;
            end
        end
    end

    // Write strobe is gated by state so an async reset drops it immediately.
    assign m_we    = (r_state == S_ACCESS) && r_we;
    assign m_addr  = r_addr;
    assign m_wdata = r_wdata;
    assign owner   = (r_state == S_IDLE) ? C_OWN_NONE : r_owner;
    assign c_ack   = (r_state == S_RESP) && (r_owner == C_OWN_CPU);
    assign d_ack   = (r_state == S_RESP) && (r_owner == C_OWN_DBG);
    assign c_rdata = r_c_rdata;
    assign d_rdata = r_d_rdata;

endmodule
`default_nettype wire
